// File: rtl/tff_count_sequencer.sv
// Sequencer for an external bank of toggle flip-flops: drives per-bit toggles so the
// bank counts modulo MODULUS up/down, and loads arbitrary values by toggle-and-verify.
module tff_count_sequencer #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_up,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic [WIDTH-1:0] i_q_in,
   output logic [WIDTH-1:0] o_t_out,
   output logic             o_busy,
   output logic             o_tc,
   output logic             o_load_done,
   output logic             o_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_LOAD,
      S_VERIFY
   } state_t;

   // MODULUS may equal 2^WIDTH, so range checks use one extra bit.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_val;
   logic             r_ret_run;
   logic             r_busy;
   logic             r_load_done;
   logic             r_err;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_val_nxt;
   logic             w_ret_nxt;
   logic             w_done_nxt;
   logic             w_err_nxt;

   logic [WIDTH-1:0] w_up_t;
   logic [WIDTH-1:0] w_dn_t;
   logic             w_q_at_top;
   logic             w_q_oor;
   logic             w_q_zero;
   logic             w_load_ok;

   assign w_q_at_top = (i_q_in >= TOP_VAL);
   assign w_q_oor    = ({1'b0, i_q_in} >= MOD_EXT);
   assign w_q_zero   = (i_q_in == '0);
   assign w_load_ok  = ({1'b0, i_load_val} < MOD_EXT);

   // Binary ripple toggles: a bit flips when all lower bits are 1 (up) or all 0 (down).
   assign w_up_t[0] = 1'b1;
   assign w_dn_t[0] = 1'b1;
   for (genvar g = 1; g < WIDTH; g++) begin : g_toggle
      assign w_up_t[g] = &i_q_in[g-1:0];
      assign w_dn_t[g] = ~|i_q_in[g-1:0];
   end

   // NOTE: async reset lives in the sensitivity list; all state updates use <= so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_val       <= '0;
         r_ret_run   <= 1'b0;
         r_busy      <= 1'b0;
         r_load_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_val       <= w_val_nxt;
         r_ret_run   <= w_ret_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_load_done <= w_done_nxt;
         r_err       <= w_err_nxt;
      end
   end

   // NOTE: every output of this block is given a default first, so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_val_nxt   = r_val;
      w_ret_nxt   = r_ret_run;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE, S_RUN: begin
            if (i_load && w_load_ok) begin
               w_state_nxt = S_LOAD;
               w_val_nxt   = i_load_val;
               w_ret_nxt   = (r_state == S_RUN);
            end else begin
               // A rejected load still lets the lower-priority stop/start act.
               w_err_nxt = i_load;
               if (i_stop) begin
                  w_state_nxt = S_IDLE;
               end else if (i_start) begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_LOAD: begin
            if (i_stop) begin
               w_ret_nxt = 1'b0;
            end else if (i_start) begin
               w_ret_nxt = 1'b1;
            end
            w_state_nxt = S_VERIFY;
         end
         S_VERIFY: begin
            if (i_stop) begin
               w_ret_nxt = 1'b0;
            end else if (i_start) begin
               w_ret_nxt = 1'b1;
            end
            if (i_q_in == r_val) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = w_ret_nxt ? S_RUN : S_IDLE;
            end else begin
               w_state_nxt = S_LOAD;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_t_out = '0;
      o_tc    = 1'b0;
      case (r_state)
         S_RUN: begin
            if (i_up) begin
               if (w_q_at_top) begin
                  o_t_out = i_q_in;
                  o_tc    = 1'b1;
               end else begin
                  o_t_out = w_up_t;
               end
            end else begin
               if (w_q_zero || w_q_oor) begin
                  o_t_out = i_q_in ^ TOP_VAL;
                  o_tc    = 1'b1;
               end else begin
                  o_t_out = w_dn_t;
               end
            end
         end
         S_LOAD:  o_t_out = i_q_in ^ r_val;
         default: o_t_out = '0;
      endcase
   end

   assign o_busy      = r_busy;
   assign o_load_done = r_load_done;
   assign o_err       = r_err;

endmodule
